// File: rtl/nf_hz_stall_unit.sv
// nanoFOX pipeline stall/flush hazard unit.
// Covers what forwarding cannot: load-use and branch-compare hazards in
// decode, and data-bus wait states from the mem stage. Keeps saturating
// per-cause stall counters for performance measurement.
module nf_hz_stall_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [4:0]       ra1_id,
  input  logic [4:0]       ra2_id,
  input  logic             branch_id,
  input  logic             branch_taken_id,
  input  logic [4:0]       wa3_iexe,
  input  logic             we_rf_iexe,
  input  logic             rf_src_iexe,
  input  logic [4:0]       wa3_imem,
  input  logic             we_rf_imem,
  input  logic             rf_src_imem,
  input  logic             lsu_req_imem,
  input  logic             lsu_ack,
  input  logic             perf_clr,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_iexe,
  output logic             stall_imem,
  output logic             stall_iwb,
  output logic             flush_id,
  output logic             flush_iexe,
  output logic             flush_imem,
  output logic             flush_iwb,
  output logic [CNT_W-1:0] ld_stall_cnt,
  output logic [CNT_W-1:0] br_stall_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt
);

  localparam int unsigned RA_W = 5;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } bus_state_e;

  bus_state_e       state_q;
  bus_state_e       state_d;

  logic             match_exe;
  logic             match_mem;
  logic             lu_hz;
  logic             br_hz;
  logic             mem_hz;

  logic             ld_inc;
  logic             br_inc;
  logic             mem_inc;

  logic [CNT_W-1:0] ld_cnt_q;
  logic [CNT_W-1:0] ld_cnt_d;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] br_cnt_d;
  logic [CNT_W-1:0] mem_cnt_q;
  logic [CNT_W-1:0] mem_cnt_d;

  // Decode-stage hazards; x0 never creates a dependency.
  always_comb begin
    match_exe = (wa3_iexe != RA_W'(0)) &&
                ((wa3_iexe == ra1_id) || (wa3_iexe == ra2_id));
    match_mem = (wa3_imem != RA_W'(0)) &&
                ((wa3_imem == ra1_id) || (wa3_imem == ra2_id));
    lu_hz     = we_rf_iexe && rf_src_iexe && match_exe;
    br_hz     = branch_id &&
                ((we_rf_iexe && match_exe) ||
                 (we_rf_imem && rf_src_imem && match_mem));
  end

  // Bus FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Bus FSM next state; a new request is not accepted while waiting.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (lsu_req_imem && !lsu_ack) state_d = MEM_WAIT;
      MEM_WAIT: if (lsu_ack)                  state_d = RUN;
      default:                                state_d = RUN;
    endcase
  end

  // Stall/flush outputs: bus wait beats decode hazards beats taken branch.
  always_comb begin
    mem_hz     = 1'b0;
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_iexe = 1'b0;
    stall_imem = 1'b0;
    stall_iwb  = 1'b0;
    flush_id   = 1'b0;
    flush_iexe = 1'b0;
    flush_imem = 1'b0;
    flush_iwb  = 1'b0;

    unique case (state_q)
      RUN:      mem_hz = lsu_req_imem && !lsu_ack;
      MEM_WAIT: mem_hz = !lsu_ack;
      default:  mem_hz = 1'b0;
    endcase

    if (resetn) begin
      if (mem_hz) begin
        stall_if   = 1'b1;
        stall_id   = 1'b1;
        stall_iexe = 1'b1;
        stall_imem = 1'b1;
        flush_iwb  = 1'b1;
      end else if (lu_hz || br_hz) begin
        stall_if   = 1'b1;
        stall_id   = 1'b1;
        flush_iexe = 1'b1;
      end else if (branch_taken_id) begin
        flush_id   = 1'b1;
      end
    end
  end

  // Per-cause increments; overlapping load-use and branch counts as a load.
  always_comb begin
    mem_inc = mem_hz;
    ld_inc  = lu_hz && !mem_hz;
    br_inc  = br_hz && !lu_hz && !mem_hz;
  end

  // Counter next values: clear wins, then saturating increment.
  always_comb begin
    ld_cnt_d  = ld_cnt_q;
    br_cnt_d  = br_cnt_q;
    mem_cnt_d = mem_cnt_q;
    if (perf_clr) begin
      ld_cnt_d  = '0;
      br_cnt_d  = '0;
      mem_cnt_d = '0;
    end else begin
      if (ld_inc && (ld_cnt_q != {CNT_W{1'b1}})) begin
        ld_cnt_d = ld_cnt_q + CNT_W'(1);
      end
      if (br_inc && (br_cnt_q != {CNT_W{1'b1}})) begin
        br_cnt_d = br_cnt_q + CNT_W'(1);
      end
      if (mem_inc && (mem_cnt_q != {CNT_W{1'b1}})) begin
        mem_cnt_d = mem_cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ld_cnt_q  <= '0;
      br_cnt_q  <= '0;
      mem_cnt_q <= '0;
    end else begin
      ld_cnt_q  <= ld_cnt_d;
      br_cnt_q  <= br_cnt_d;
      mem_cnt_q <= mem_cnt_d;
    end
  end

  assign ld_stall_cnt  = ld_cnt_q;
  assign br_stall_cnt  = br_cnt_q;
  assign mem_stall_cnt = mem_cnt_q;

endmodule

// File: doc/nf_hz_stall_unit.md
# nf_hz_stall_unit

Stall/flush hazard unit for the nanoFOX 5-stage pipeline; it complements the forwarding path by covering every hazard that forwarding cannot resolve. It detects load-use and branch-compare hazards in decode and holds the pipeline while the data-bus handshake from the mem stage is pending. It drives per-stage stall and flush controls and keeps saturating per-cause stall counters for performance measurement.

## Interface
- CNT_W, 16, width of each stall performance counter
- clk  input  1  core clock, all state on rising edge
- resetn  input  1  asynchronous active-low reset
- ra1_id, ra2_id  input  5 each  source register addresses in decode
- branch_id  input  1  decode holds a branch that compares rd1/rd2
- branch_taken_id  input  1  branch in decode resolved taken
- wa3_iexe  input  5  destination register in exe
- we_rf_iexe  input  1  exe instruction writes register file
- rf_src_iexe  input  1  exe instruction is a load
- wa3_imem  input  5  destination register in mem
- we_rf_imem  input  1  mem instruction writes register file
- rf_src_imem  input  1  mem instruction is a load
- lsu_req_imem  input  1  mem stage issues a data-bus request this cycle
- lsu_ack  input  1  data-bus request completed
- perf_clr  input  1  synchronous clear of all counters
- stall_if, stall_id, stall_iexe, stall_imem, stall_iwb  output  1 each  hold stage register
- flush_id, flush_iexe, flush_imem, flush_iwb  output  1 each  load bubble into stage register
- ld_stall_cnt, br_stall_cnt, mem_stall_cnt  output  CNT_W each  per-cause stall cycle counts

## Operation
- Register-match helper: match(r) = (r != 0) && (r == ra1_id || r == ra2_id).
- lu_hz = we_rf_iexe && rf_src_iexe && match(wa3_iexe).
- br_hz = branch_id && ((we_rf_iexe && match(wa3_iexe)) || (we_rf_imem && rf_src_imem && match(wa3_imem))).
- Bus FSM, states RUN and MEM_WAIT:
  - RUN: lsu_req_imem && !lsu_ack -> MEM_WAIT; otherwise stay.
  - MEM_WAIT: lsu_ack -> RUN; otherwise stay; lsu_req_imem is ignored in this state.
- mem_hz = (RUN && lsu_req_imem && !lsu_ack) || (MEM_WAIT && !lsu_ack).
- Priority is mem_hz > lu_hz/br_hz > branch_taken_id.
- On mem_hz: stall_if, stall_id, stall_iexe and stall_imem are 1; flush_iwb is 1; all other outputs are 0. Decode hazards are masked.
- On lu_hz or br_hz without mem_hz: stall_if and stall_id are 1; flush_iexe is 1; everything else is 0; branch_taken_id is ignored.
- On branch_taken_id with no hazard: flush_id is 1 and all stalls are 0.
- stall_iwb is tied to 0. flush_imem is reserved and is 0.
- Counters increment once per cycle in which their cause drives the stall:
  - mem_stall_cnt counts on mem_hz.
  - ld_stall_cnt counts on lu_hz && !mem_hz.
  - br_stall_cnt counts on br_hz && !lu_hz && !mem_hz, so a cycle with both lu_hz and br_hz counts as a load stall.
- Counters saturate at all-ones. perf_clr wins over an increment in the same cycle.

## Timing
- Stall and flush outputs are combinational from the inputs and the FSM state, with zero latency. Counters and FSM update on the rising edge.
- Reset (async, resetn = 0) sets FSM to RUN and all counters to 0. While resetn is low, every stall_* and flush_* output is forced to 0.
- Reset mid-MEM_WAIT returns the FSM to RUN immediately. The first cycle after reset is evaluated from RUN.
- A load-use stall lasts exactly 1 cycle. The bubble in exe clears lu_hz, so the stall self-terminates.
- br_hz lasts 1 cycle for an exe ALU producer and 2 cycles for an exe load producer (load-use cycle, then the mem-load cycle).
- A single-cycle bus access (req && ack in the same cycle) causes no stall. An access with ack N cycles after req stalls N cycles.

## Test plan
- Load-use: exe load wa3 = 5, ra1_id = 5 -> stall_if = stall_id = flush_iexe = 1 for exactly 1 cycle; ld_stall_cnt = 1.
- x0 guard: exe load wa3 = 0, ra1_id = 0 -> no stall, counters unchanged.
- Branch on load result: branch_id = 1, ra2_id = 7, exe load wa3 = 7 -> 2 stall cycles; ld_stall_cnt = 1, br_stall_cnt = 1.
- Bus wait: req at cycle 0 with ack at cycle 3 -> stall_imem = flush_iwb = 1 on cycles 0-2, released on cycle 3; mem_stall_cnt = 3. In a second run, a concurrent load-use during the wait is masked and ld_stall_cnt stays 0.
- Taken branch without hazard -> flush_id = 1 for 1 cycle, no stalls. Taken branch coinciding with lu_hz -> flush_id = 0.
- Saturation and clear: with CNT_W = 4, 20 mem-stall cycles -> mem_stall_cnt holds 15; perf_clr together with a stall cycle -> 0. Asserting resetn = 0 in MEM_WAIT -> all outputs 0, FSM in RUN after release.
